// File: rtl/pc_sequencer_if.sv
// Bus between the main control FSM and the program-counter sequencer.
// The control FSM (master) presents an instruction's opcode and fields and
// pulses pc_update; the sequencer (slave) reports the PC, the commit
// source, the stack depth and the sticky fault.
interface pc_sequencer_if #(
    parameter int PC_WIDTH     = 16,
    parameter int OFFSET_WIDTH = 8,
    parameter int JUMP_WIDTH   = 12,
    parameter int STACK_DEPTH  = 8
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    // Handshake: pc_update is a single-cycle commit strobe with no ready
    // path back. Opcode and operand fields are sampled only on the rising
    // edge where pc_update=1, and the committed PC is visible one cycle
    // later. flag_we is independent of pc_update. It loads the flag
    // register on any edge. When it coincides with pc_update, the incoming
    // flags also steer that commit's branch decision.
    logic [3:0]              opcode;
    logic [OFFSET_WIDTH-1:0] branch_off;
    logic [JUMP_WIDTH-1:0]   jump_tgt;
    logic                    alu_zero;
    logic                    alu_neg;
    logic                    flag_we;
    logic                    pc_update;

    logic [PC_WIDTH-1:0]     pc;
    logic [1:0]              pc_src;
    logic                    branch_taken;
    logic [CW-1:0]           stack_count;
    logic                    fault;
    logic [1:0]              fault_code;
    logic                    state_dbg;     // 0 RUN, 1 FAULT

    modport master (
        output opcode, branch_off, jump_tgt, alu_zero, alu_neg, flag_we, pc_update,
        input  pc, pc_src, branch_taken, stack_count, fault, fault_code, state_dbg
    );

    modport slave (
        input  opcode, branch_off, jump_tgt, alu_zero, alu_neg, flag_we, pc_update,
        output pc, pc_src, branch_taken, stack_count, fault, fault_code, state_dbg
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multi-cycle RISC core.
// It holds the PC, the condition flags and a return-address stack. On each
// commit strobe it chooses the next PC: sequential, a taken branch, a jump
// or call, or a return. A stack overflow or underflow locks the unit in
// FAULT until reset.
module pc_sequencer #(
    parameter int PC_WIDTH     = 16,
    parameter int OFFSET_WIDTH = 8,
    parameter int JUMP_WIDTH   = 12,
    parameter int STACK_DEPTH  = 8
) (
    input logic            clk,
    input logic            rst_n,
    pc_sequencer_if.slave  bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [3:0] OP_BGT  = 4'b1000;
    localparam logic [3:0] OP_BLT  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_CALL = 4'b1101;
    localparam logic [3:0] OP_RET  = 4'b1110;

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_JMP = 2'd1;
    localparam logic [1:0] SRC_BR  = 2'd2;
    localparam logic [1:0] SRC_RET = 2'd3;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_OVER  = 2'd1;
    localparam logic [1:0] FC_UNDER = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                state_q, state_nx;
    logic [PC_WIDTH-1:0]   pc_q, pc_nx;
    logic [1:0]            src_q, src_nx;
    logic                  taken_q, taken_nx;
    logic [CW-1:0]         count_q, count_nx;
    logic                  fault_q, fault_nx;
    logic [1:0]            code_q, code_nx;
    logic                  flag_z_q, flag_n_q;

    logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];
    logic                  push_en;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         top_idx;

    logic [PC_WIDTH-1:0]   off_ext;
    logic [PC_WIDTH-1:0]   pc_seq;
    logic [PC_WIDTH-1:0]   pc_br;
    logic [PC_WIDTH-1:0]   pc_jmp;
    logic                  eff_z, eff_n;
    logic                  cond_true;
    logic                  stack_full;
    logic                  stack_empty;

    // The branch offset is signed and is widened to PC width. Addition then
    // wraps modulo 2^PC_WIDTH.
    generate
        if (OFFSET_WIDTH < PC_WIDTH) begin : g_off_ext
            assign off_ext = {{(PC_WIDTH - OFFSET_WIDTH){bus.branch_off[OFFSET_WIDTH-1]}},
                              bus.branch_off};
        end else begin : g_off_trunc
            assign off_ext = bus.branch_off[PC_WIDTH-1:0];
        end
    endgenerate

    // A jump keeps the current page (the PC high bits) unless the field
    // covers the whole PC.
    generate
        if (JUMP_WIDTH < PC_WIDTH) begin : g_jmp_page
            assign pc_jmp = {pc_q[PC_WIDTH-1:JUMP_WIDTH], bus.jump_tgt};
        end else begin : g_jmp_full
            assign pc_jmp = bus.jump_tgt[PC_WIDTH-1:0];
        end
    endgenerate

    assign pc_seq      = pc_q + PC_WIDTH'(1);
    assign pc_br       = pc_q + off_ext;
    assign stack_full  = (count_q == CW'(STACK_DEPTH));
    assign stack_empty = (count_q == '0);
    assign wr_idx      = AW'(count_q);
    assign top_idx     = AW'(count_q - CW'(1));

    // The incoming ALU flags bypass the flag register when they arrive in
    // the same cycle as the commit.
    assign eff_z = bus.flag_we ? bus.alu_zero : flag_z_q;
    assign eff_n = bus.flag_we ? bus.alu_neg  : flag_n_q;

    // Branch condition for the current opcode; 0 for non-branch opcodes.
    always_comb begin
        cond_true = 1'b0;
        case (bus.opcode)
            OP_BGT:  cond_true = !eff_z && !eff_n;
            OP_BLT:  cond_true = eff_n;
            OP_BEQ:  cond_true = eff_z;
            OP_BNE:  cond_true = !eff_z;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-state and commit decision: everything holds unless RUN sees a
    // commit strobe. branch_taken clears itself every cycle.
    always_comb begin
        state_nx = state_q;
        pc_nx    = pc_q;
        src_nx   = src_q;
        taken_nx = 1'b0;
        count_nx = count_q;
        fault_nx = fault_q;
        code_nx  = code_q;
        push_en  = 1'b0;

        if (state_q == ST_RUN && bus.pc_update) begin
            case (bus.opcode)
                OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
                    if (cond_true) begin
                        pc_nx    = pc_br;
                        src_nx   = SRC_BR;
                        taken_nx = 1'b1;
                    end else begin
                        pc_nx  = pc_seq;
                        src_nx = SRC_SEQ;
                    end
                end
                OP_JMP: begin
                    pc_nx  = pc_jmp;
                    src_nx = SRC_JMP;
                end
                OP_CALL: begin
                    if (stack_full) begin
                        state_nx = ST_FAULT;
                        fault_nx = 1'b1;
                        code_nx  = FC_OVER;
                    end else begin
                        push_en  = 1'b1;
                        pc_nx    = pc_jmp;
                        src_nx   = SRC_JMP;
                        count_nx = count_q + CW'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        state_nx = ST_FAULT;
                        fault_nx = 1'b1;
                        code_nx  = FC_UNDER;
                    end else begin
                        pc_nx    = stack_mem[top_idx];
                        src_nx   = SRC_RET;
                        count_nx = count_q - CW'(1);
                    end
                end
                default: begin
                    pc_nx  = pc_seq;
                    src_nx = SRC_SEQ;
                end
            endcase
        end
    end

    // State, PC and status registers; reset wins over a same-cycle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            src_q   <= SRC_SEQ;
            taken_q <= 1'b0;
            count_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_nx;
            pc_q    <= pc_nx;
            src_q   <= src_nx;
            taken_q <= taken_nx;
            count_q <= count_nx;
            fault_q <= fault_nx;
            code_q  <= code_nx;
        end
    end

    // The flag register tracks the ALU whenever flag_we is high, even in FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (bus.flag_we) begin
            flag_z_q <= bus.alu_zero;
            flag_n_q <= bus.alu_neg;
        end
    end

    // Return-address storage: a CALL pushes the address after the call.
    // Contents are not reset, because stack_count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[wr_idx] <= pc_seq;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_src       = src_q;
    assign bus.branch_taken = taken_q;
    assign bus.stack_count  = count_q;
    assign bus.fault        = fault_q;
    assign bus.fault_code   = code_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-generation program-counter unit for the multi-cycle RISC core.
- Owns the PC register, the condition-flag register and a parametrised hardware return-address stack.
- Resolves the branch, jump, call and return decision and commits the new PC on a single-cycle update strobe from the main control FSM.
- Generalises the earlier combinational PC-source selector:
  - adds target arithmetic and CALL/RET stack storage;
  - adds sticky fault detection and a one-cycle commit handshake.

Parameters:
PC_WIDTH, 16, PC and return-address width (word-addressed)
OFFSET_WIDTH, 8, signed branch-offset width, sign-extended to PC_WIDTH
JUMP_WIDTH, 12, absolute jump-field width; replaces PC low bits
STACK_DEPTH, 8, return-address stack entries (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  4  instruction opcode (BGT 1000, BLT 1001, BEQ 1010, BNE 1011, JMP 1100, CALL 1101, RET 1110, others sequential)
branch_off  in  OFFSET_WIDTH  signed branch offset
jump_tgt  in  JUMP_WIDTH  absolute jump target field
alu_zero  in  1  ALU zero flag
alu_neg  in  1  ALU negative flag
flag_we  in  1  capture alu_zero/alu_neg into flag register
pc_update  in  1  one-cycle commit strobe from control FSM
pc  out  PC_WIDTH  current PC
pc_src  out  2  registered source of last commit: 0 seq, 1 jump/call, 2 branch taken, 3 ret
branch_taken  out  1  one-cycle pulse, cycle after a taken branch commit
stack_count  out  clog2(STACK_DEPTH+1)  valid entries on stack
fault  out  1  sticky: 1 on stack overflow or underflow
fault_code  out  2  0 none, 1 overflow (CALL on full), 2 underflow (RET on empty)

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state:
  - pc, pc_src, branch_taken, stack_count, fault, fault_code = 0;
  - flag register = 0;
  - stack contents don't-care;
  - FSM = RUN.
- Flag register:
  - loads {alu_zero, alu_neg} on clk when flag_we=1.
  - Branch decision uses effective flags: the incoming ALU flags when flag_we=1 in the same cycle as pc_update (bypass), otherwise the stored flags.
- Branch conditions, on effective flags (Z, N):
  - BGT: Z=0 and N=0;
  - BLT: N=1;
  - BEQ: Z=1;
  - BNE: Z=0.
- Next-PC computation (all arithmetic modulo 2^PC_WIDTH, wrap-around silent):
  - sequential: pc+1;
  - taken branch: pc + sext(branch_off);
  - JMP/CALL: {pc[PC_WIDTH-1:JUMP_WIDTH], jump_tgt}; if JUMP_WIDTH >= PC_WIDTH, use jump_tgt[PC_WIDTH-1:0];
  - RET: top of stack.
- Commit latency:
  - pc, pc_src and stack update on the clk edge where pc_update=1; new pc is visible the next cycle.
  - pc_update=0: all state holds, except the flag register and the branch_taken self-clear.
- branch_taken: high for exactly one cycle after a commit whose branch condition was true; never set for JMP/CALL/RET.
- CALL push:
  - pushes pc+1 at stack[stack_count], then stack_count+1.
  - If stack_count==STACK_DEPTH: no push, pc holds, fault=1, fault_code=1.
- RET pop:
  - pc <= stack[stack_count-1], then stack_count-1.
  - If stack_count==0: pc holds, fault=1, fault_code=2.
- FSM states:
  - RUN: commits processed as above. Overflow or underflow moves to FAULT.
  - FAULT: pc_update ignored; pc, stack_count and pc_src frozen; flag register still updates; fault held. Exit only via rst_n.
- Reset asserted mid-operation (including the same cycle as pc_update) wins unconditionally.
- Opcodes 0000-0111 and 1111 commit sequentially (pc_src=0).

Test Plan:
- Reset, then 3 pc_update with opcode 0000 -> pc 0,1,2,3; pc_src=0; branch_taken never high.
- pc=0x0010, flag_we with Z=0/N=1 a cycle earlier, BLT branch_off=8'hFC, pc_update -> pc=0x000C, pc_src=2, branch_taken one cycle; same with BGT -> pc=0x0011, pc_src=0.
- Same-cycle bypass: stored Z=0, BEQ with flag_we=1 alu_zero=1 on the pc_update cycle, branch_off=5, pc=0x20 -> pc=0x25.
- pc=0xA005, CALL jump_tgt=12'h123 -> pc=0xA123, stack_count=1, pc_src=1; then RET -> pc=0xA006, stack_count=0, pc_src=3.
- STACK_DEPTH=8: 8 CALLs succeed, 9th CALL -> fault=1, fault_code=1, pc unchanged; further pc_update (JMP) ignored; rst_n low mid-fault -> all zero.
- RET on empty stack after reset -> fault=1, fault_code=2, pc=0. Separately, pc=0xFFFF with opcode 0000 -> pc wraps to 0x0000 with no fault.
